spi_regfile: RTL and testbench

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile_pkg.sv | 15 +
 rtl/spi_sync.sv | 26 ++
 rtl/spi_regfile.sv | 179 +++++++++++++++++
 tb/tb_spi_regfile.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI-accessible configuration register file.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StCommit
    } state_e;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned RW_BIT = 7;
    localparam int unsigned ADDR_W = 7;

endpackage

// File: rtl/spi_sync.sv
// Three-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses.
module spi_sync #(
    parameter logic RstVal = 1'b0
) (
    input  logic CLK,
    input  logic RSTb,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            sync_q <= {3{RstVal}};
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    // Stage 1 is the settled level; stage 2 is its one-cycle-old copy.
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 slave exposing NUM_REGS configuration registers; writes commit only on a well-formed frame.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_REGS = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {32'h0, 32'h0, 32'h7, 32'h001312eb}
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic                       SCK,
    input  logic                       CS,
    input  logic                       MOSI,
    output logic                       MISO,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic                       frame_err
);

    localparam int unsigned CntW = $clog2(DATA_W + 2);
    localparam logic [CntW-1:0] CntSat = CntW'(DATA_W + 1);

    logic cs_rise, cs_fall, sck_rise, sck_fall, mosi_s;
    logic [1:0] mosi_q;

    spi_sync #(.RstVal(1'b1)) u_cs_sync (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .d_i    (CS),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync #(.RstVal(1'b0)) u_sck_sync (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .d_i    (SCK),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Two flops keep MOSI aligned with the settled stage of the SCK synchroniser.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[0], MOSI};
        end
    end
    assign mosi_s = mosi_q[1];

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d, cmd_next;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic [NUM_REGS-1:0] stb_q, stb_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   rd_lookup;

    assign cmd_next = {cmd_q[CMD_W-2:0], mosi_s};

    always_comb begin
        rd_lookup = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (ADDR_W'(i) == cmd_next[ADDR_W-1:0]) rd_lookup = regs_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        out_d   = out_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        regs_d  = regs_q;
        stb_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                    cmd_d   = '0;
                    data_d  = '0;
                end
            end
            StCmd: begin
                if (cs_rise) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (sck_rise) begin
                    cmd_d = cmd_next;
                    if (cnt_q == CntW'(CMD_W - 1)) begin
                        state_d = StData;
                        cnt_d   = '0;
                        addr_d  = cmd_next[ADDR_W-1:0];
                        rd_d    = cmd_next[RW_BIT];
                        out_d   = cmd_next[RW_BIT] ? rd_lookup : '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StData: begin
                if (cs_rise) begin
                    if (cnt_q == CntW'(DATA_W)) begin
                        state_d = StCommit;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        data_d = {data_q[DATA_W-2:0], mosi_s};
                        if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
                    end
                    // MSB is already on MISO; shifting starts only after the first data bit.
                    if (sck_fall && cnt_q != '0) out_d = {out_q[DATA_W-2:0], 1'b0};
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (!rd_q) begin
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        if (ADDR_W'(i) == addr_q) begin
                            regs_d[i] = data_q;
                            stb_d[i]  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            out_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            stb_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_stb    = stb_q;
    assign frame_err = err_q;
    assign MISO      = (state_q == StData) & out_q[DATA_W-1];

endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: frame-level register model, per-cycle compare, directed SPI frames.
module tb_spi_regfile;

    localparam int NR = 4;
    localparam logic [127:0] RV = {32'h0, 32'h0, 32'h7, 32'h001312eb};

    logic         CLK = 1'b0;
    logic         RSTb = 1'b0;
    logic         SCK = 1'b0;
    logic         CS = 1'b1;
    logic         MOSI = 1'b0;
    logic         MISO;
    logic [127:0] regs_flat;
    logic [3:0]   wr_stb;
    logic         frame_err;

    spi_regfile dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .SCK       (SCK),
        .CS        (CS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .regs_flat (regs_flat),
        .wr_stb    (wr_stb),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_regs [NR];
    bit          skip = 1'b1;
    logic [3:0]  pend_stb = 4'h0;
    int          pend_idx = 0;
    logic [31:0] pend_val = 32'h0;
    bit          pend_err = 1'b0;
    logic [31:0] rdata;

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        logic [127:0] rv_v;
        rv_v = RV;
        for (int i = 0; i < NR; i++) exp_regs[i] = rv_v[i*32 +: 32];
        pend_stb = 4'h0;
        pend_err = 1'b0;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    always @(negedge CLK) begin
        if (!skip) begin
            if (wr_stb !== 4'h0) begin
                checks++;
                if (wr_stb !== pend_stb) begin
                    errors++;
                    $display("FAIL wr_stb: got %b, expected %b", wr_stb, pend_stb);
                end
                if (pend_stb != 4'h0) begin
                    exp_regs[pend_idx] = pend_val;
                    pend_stb = 4'h0;
                end
            end
            checks++;
            if (regs_flat !== model_flat()) begin
                errors++;
                $display("FAIL regs_flat: got %h, expected %h", regs_flat, model_flat());
            end
            if (frame_err !== 1'b0) begin
                checks++;
                if (!pend_err) begin
                    errors++;
                    $display("FAIL frame_err: got %b, expected 0", frame_err);
                end
                pend_err = 1'b0;
            end
        end
    end

    // SCK half-period is 8 CLK cycles; all edges fall 1ns after a CLK rise.
    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] wdata, input int cmd_bits,
                             input int nbits, input bit do_rst, output logic [31:0] rd_out);
        int          addr;
        bit          rd;
        logic [31:0] exp_rd;
        logic        exp_bit;
        addr   = int'(cmd[6:0]);
        rd     = cmd[7];
        exp_rd = (rd && addr < NR) ? exp_regs[addr] : 32'h0;
        rd_out = 32'h0;
        CS = 1'b0;
        #80;
        for (int i = 0; i < cmd_bits; i++) begin
            MOSI = cmd[7-i];
            #80;
            chk32("miso_cmd", {31'h0, MISO}, 32'h0);
            SCK = 1'b1;
            #80;
            SCK = 1'b0;
        end
        if (cmd_bits == 8) begin
            for (int i = 0; i < nbits; i++) begin
                MOSI = (i < 32) ? wdata[31-i] : 1'b1;
                #80;
                if (i < 32) begin
                    rd_out[31-i] = MISO;
                    exp_bit = rd ? exp_rd[31-i] : 1'b0;
                    chk32("miso_data", {31'h0, MISO}, {31'h0, exp_bit});
                end
                SCK = 1'b1;
                #80;
                SCK = 1'b0;
                if (do_rst && i == 7) begin
                    #80;
                    skip = 1'b1;
                    RSTb = 1'b0;
                    CS   = 1'b1;
                    #10;
                    RSTb = 1'b1;
                    model_reset();
                    skip = 1'b0;
                    #160;
                    return;
                end
            end
        end
        #80;
        if (cmd_bits != 8 || nbits != 32) begin
            pend_err = 1'b1;
        end else if (!rd && addr < NR) begin
            pend_idx = addr;
            pend_val = wdata;
            pend_stb = 4'b0001 << addr;
        end
        CS = 1'b1;
        #120;
        chk32("wr_stb_seen", {28'h0, pend_stb}, 32'h0);
        chk32("frame_err_seen", {31'h0, pend_err}, 32'h0);
        pend_stb = 4'h0;
        pend_err = 1'b0;
        #80;
    endtask

    initial begin
        model_reset();
        #36;
        RSTb = 1'b1;
        skip = 1'b0;
        #40;
        chk32("rst_reg0", regs_flat[31:0], 32'h001312eb);
        chk32("rst_reg1", regs_flat[63:32], 32'h00000007);
        chk32("rst_wr_stb", {28'h0, wr_stb}, 32'h0);
        chk32("rst_frame_err", {31'h0, frame_err}, 32'h0);

        spi_frame(8'h01, 32'hDEADBEEF, 8, 32, 1'b0, rdata);
        chk32("wr_reg1", regs_flat[63:32], 32'hDEADBEEF);
        spi_frame(8'h81, 32'h0, 8, 32, 1'b0, rdata);
        chk32("rd_reg1", rdata, 32'hDEADBEEF);

        spi_frame(8'h00, 32'hFFFFFFFF, 8, 20, 1'b0, rdata);
        chk32("short_reg0", regs_flat[31:0], 32'h001312eb);

        spi_frame(8'h05, 32'h12345678, 8, 32, 1'b0, rdata);
        spi_frame(8'h85, 32'h0, 8, 32, 1'b0, rdata);
        chk32("rd_oob", rdata, 32'h0);

        spi_frame(8'h02, 32'h11111111, 8, 33, 1'b0, rdata);
        chk32("overrun_reg2", regs_flat[95:64], 32'h0);
        spi_frame(8'h03, 32'h0, 4, 0, 1'b0, rdata);

        spi_frame(8'h02, 32'hA5A50F0F, 8, 32, 1'b0, rdata);
        spi_frame(8'h82, 32'h0, 8, 32, 1'b0, rdata);
        chk32("rd_reg2", rdata, 32'hA5A50F0F);

        spi_frame(8'h02, 32'h5555AAAA, 8, 32, 1'b1, rdata);
        chk32("midrst_reg2", regs_flat[95:64], 32'h0);
        chk32("midrst_reg1", regs_flat[63:32], 32'h00000007);
        spi_frame(8'h02, 32'hCAFEF00D, 8, 32, 1'b0, rdata);
        spi_frame(8'h82, 32'h0, 8, 32, 1'b0, rdata);
        chk32("rd_reg2_after_rst", rdata, 32'hCAFEF00D);
        spi_frame(8'h80, 32'h0, 8, 32, 1'b0, rdata);
        chk32("rd_reg0", rdata, 32'h001312eb);

        spi_frame(8'h03, 32'h0BADF00D, 8, 32, 1'b0, rdata);
        spi_frame(8'h83, 32'h0, 8, 32, 1'b0, rdata);
        chk32("rd_reg3", rdata, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
